// File: rtl/emg_spike_counter.sv
// EMG spike-count producer: counts rising edges on a population of spike lines
// over a programmable window of clk cycles and presents the saturating window total.
module emg_spike_counter #(
  parameter int NUM_NEURONS = 16,
  parameter int CNT_W       = 32,
  parameter int LEN_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic [LEN_W-1:0]       window_len,
  output logic [CNT_W-1:0]       i_spike_cnt,
  output logic                   cnt_valid,
  output logic                   cnt_sat
);

  localparam int POP_W = $clog2(NUM_NEURONS + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX_W = SUM_W'({CNT_W{1'b1}});

  function automatic logic [POP_W-1:0] popcount(input logic [NUM_NEURONS-1:0] v);
    logic [POP_W-1:0] c;
    c = {POP_W{1'b0}};
    for (int i = 0; i < NUM_NEURONS; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

  logic [NUM_NEURONS-1:0] spike_prev_q, spike_prev_d;
  logic [POP_W-1:0]       pop_q, pop_d;
  logic [CNT_W-1:0]       acc_q, acc_d;
  logic                   sat_q, sat_d;
  logic [LEN_W-1:0]       win_cnt_q, win_cnt_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   cnt_sat_q, cnt_sat_d;

  logic [NUM_NEURONS-1:0] rise_s;
  logic [SUM_W-1:0]       sum_wide_s;
  logic                   ovf_s;
  logic [CNT_W-1:0]       sum_sat_s;
  logic                   win_end_s;

  // Edge detect, saturating add and window-end decode.
  always_comb begin
    rise_s     = spike_in & ~spike_prev_q;
    sum_wide_s = SUM_W'(acc_q) + SUM_W'(pop_q);
    ovf_s      = (sum_wide_s > CNT_MAX_W);
    sum_sat_s  = ovf_s ? {CNT_W{1'b1}} : sum_wide_s[CNT_W-1:0];
    win_end_s  = enable && (win_cnt_q == (len_q - LEN_W'(1)));
  end

  // Next-state logic for the edge pipeline, window counter and accumulator.
  always_comb begin
    spike_prev_d = spike_in;
    pop_d        = enable ? popcount(rise_s) : {POP_W{1'b0}};
    acc_d        = acc_q;
    sat_d        = sat_q;
    win_cnt_d    = win_cnt_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    cnt_sat_d    = cnt_sat_q;
    valid_d      = 1'b0;

    if (win_end_s) begin
      win_cnt_d = {LEN_W{1'b0}};
      acc_d     = {CNT_W{1'b0}};
      sat_d     = 1'b0;
      cnt_d     = sum_sat_s;
      cnt_sat_d = sat_q | ovf_s;
      valid_d   = 1'b1;
    end else if (enable) begin
      win_cnt_d = win_cnt_q + LEN_W'(1);
      acc_d     = sum_sat_s;
      sat_d     = sat_q | ovf_s;
    end else begin
      win_cnt_d = win_cnt_q;
      acc_d     = acc_q;
      sat_d     = sat_q;
    end

    // Length is only sampled between windows or while paused, so a running window is never cut short.
    if (win_end_s || !enable) begin
      len_d = (window_len == {LEN_W{1'b0}}) ? LEN_W'(1) : window_len;
    end else begin
      len_d = len_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spike_prev_q <= {NUM_NEURONS{1'b0}};
      pop_q        <= {POP_W{1'b0}};
      acc_q        <= {CNT_W{1'b0}};
      sat_q        <= 1'b0;
      win_cnt_q    <= {LEN_W{1'b0}};
      len_q        <= LEN_W'(1);
      cnt_q        <= {CNT_W{1'b0}};
      valid_q      <= 1'b0;
      cnt_sat_q    <= 1'b0;
    end else begin
      spike_prev_q <= spike_prev_d;
      pop_q        <= pop_d;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      win_cnt_q    <= win_cnt_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      cnt_sat_q    <= cnt_sat_d;
    end
  end

  assign i_spike_cnt = cnt_q;
  assign cnt_valid   = valid_q;
  assign cnt_sat     = cnt_sat_q;

endmodule
